fp_wrb_buffer: RTL and testbench
================================

// Module: fp_wrb_buffer
// PURPOSE
//  Writeback buffer that sits directly upstream of the FP physical regfile write ports.
//  Accepts up to 4 FP results per cycle from falu1, falu2, lsu and fdivsqrt using valid/ready.
//  Stores them in an in-order circular FIFO.
//  Drains at most 2 entries per cycle onto the regfile's two write lanes.
//  Removes the 4-into-2 port pressure without silently dropping any result.
// PARAMETERS
//  DEPTH          8   FIFO entries; power of two, >= 4
//  PTR_W          3   log2(DEPTH)
//  REG_SIZE_WIDTH 6   physical register address width
//  XLEN           64  data width
// PORTS
//  clk                   in   1       clock
//  rst                   in   1       sync reset, active-high
//  <src>_valid_i         in   1       src in {falu1,falu2,lsu,fdivsqrt}: result valid
//  <src>_address_i       in   RSW     destination physical reg
//  <src>_data_i          in   XLEN    result data
//  <src>_ready_o         out  1       buffer accepts <src> this cycle
//  wr_first_valid_o      out  1       lane 0 write enable (older entry)
//  wr_first_address_o    out  RSW     lane 0 address
//  wr_first_data_o       out  XLEN    lane 0 data
//  wr_second_valid_o     out  1       lane 1 write enable (younger entry)
//  wr_second_address_o   out  RSW     lane 1 address
//  wr_second_data_o      out  XLEN    lane 1 data
//  count_o               out  PTR_W+1 occupied entries (registered)
//  empty_o               out  1       count_o == 0
// BEHAVIOUR
//  State:
//   - head_q and tail_q are PTR_W-bit pointers that wrap modulo DEPTH.
//   - count_q is PTR_W+1 bits wide.
//  Reset:
//   - head, tail and count are 0; all wr_* outputs are 0; empty_o is 1.
//   - All *_ready_o are forced 0 while rst is high.
//  Accept (fixed priority falu1 > falu2 > lsu > fdivsqrt):
//   - free = DEPTH - count_q. It uses the registered count only; same-cycle drain is NOT credited.
//   - ready_k = (free > number of valid sources with higher priority than k). It is combinational.
//   - Handshake = valid & ready. Data must stay stable while valid & !ready; the source retries.
//  Enqueue:
//   - Accepted entries are written at tail, tail+1, ... in priority order.
//   - tail advances by the number of accepted entries.
//   - Writes to address 0 are handshaken (ready as normal) but NOT stored, since P0 is hardwired zero.
//  Drain:
//   - Registered outputs. An entry enqueued in cycle N can appear on a write lane no earlier than N+1.
//   - Each cycle, the lanes show the oldest min(count_q,2) entries: first = head, second = head+1.
//   - The regfile never stalls, so the displayed entries are popped unconditionally.
//   - Lanes with no entry drive valid=0 and address/data=0.
//   - Same address on both lanes is legal; lane ordering makes the second (younger) write win.
//  Simultaneous:
//   - count_d = count_q + enq_cnt - deq_cnt. It never exceeds DEPTH and never underflows.
//   - Pointer wrap is handled modulo DEPTH.
//  No flush: FP results are never squashed at this point; the ROB ignores stale tags.
//  Reset mid-operation: all contents are discarded; outputs are 0 in the cycle after rst.
// TESTING
//  1. Empty buffer, all 4 valid (addr 3,4,5,6; data A,B,C,D) for 1 cycle:
//     all ready=1; next cycle lanes=(3,A),(4,B); the cycle after =(5,C),(6,D); then empty_o=1.
//  2. Hold all 4 valid for 4 cycles:
//     count 0->4->6->6; cycle 3 lsu/fdivsqrt ready=0, falu1/falu2 ready=1; no entry lost or reordered.
//  3. Only fdivsqrt valid when free=1: ready=1. falu1+fdivsqrt valid when free=1: falu1 ready, fdivsqrt not.
//  4. falu1 addr 0 with falu2 addr 9 from empty: both ready; next cycle lane0=(9,data), lane1 invalid.
//  5. Wrap: push 11 entries with ascending data, 1 per cycle then 2 per cycle:
//     drain order is strictly ascending across head wrap.
//  6. Assert rst with count=5: next cycle count_o=0, all wr_*_valid_o=0, ready=1 once rst drops.

Source files
------------

// File: rtl/fp_wrb_buffer.sv
// FP writeback buffer: accepts up to four FP results per cycle into an in-order FIFO
// and drains up to two per cycle onto the regfile's two registered write lanes.
module fp_wrb_buffer #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PTR_W          = 3,
  parameter int unsigned REG_SIZE_WIDTH = 6,
  parameter int unsigned XLEN           = 64
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      falu1_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] falu1_address_i,
  input  logic [XLEN-1:0]           falu1_data_i,
  output logic                      falu1_ready_o,

  input  logic                      falu2_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] falu2_address_i,
  input  logic [XLEN-1:0]           falu2_data_i,
  output logic                      falu2_ready_o,

  input  logic                      lsu_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] lsu_address_i,
  input  logic [XLEN-1:0]           lsu_data_i,
  output logic                      lsu_ready_o,

  input  logic                      fdivsqrt_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] fdivsqrt_address_i,
  input  logic [XLEN-1:0]           fdivsqrt_data_i,
  output logic                      fdivsqrt_ready_o,

  output logic                      wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0] wr_first_address_o,
  output logic [XLEN-1:0]           wr_first_data_o,
  output logic                      wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0] wr_second_address_o,
  output logic [XLEN-1:0]           wr_second_data_o,

  output logic [PTR_W:0]            count_o,
  output logic                      empty_o
);

  localparam int unsigned NSRC  = 4;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_SIZE_WIDTH-1:0] addr;
    logic [XLEN-1:0]           data;
  } wrb_entry_t;

  logic [NSRC-1:0]  src_valid;
  logic [NSRC-1:0]  src_ready;
  logic [NSRC-1:0]  src_fire;
  wrb_entry_t       src_entry [NSRC];

  wrb_entry_t       mem_q [DEPTH];
  wrb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q;

  logic [CNT_W-1:0] free_c;
  logic [CNT_W-1:0] n_hi;
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] deq_cnt;

  logic             lane0_valid_q, lane1_valid_q;
  wrb_entry_t       lane0_q, lane1_q;
  logic             lane0_valid_d, lane1_valid_d;
  wrb_entry_t       lane0_d, lane1_d;

  // Index 0 is the highest-priority source
  assign src_valid    = {fdivsqrt_valid_i, lsu_valid_i, falu2_valid_i, falu1_valid_i};
  assign src_entry[0] = '{addr: falu1_address_i,    data: falu1_data_i};
  assign src_entry[1] = '{addr: falu2_address_i,    data: falu2_data_i};
  assign src_entry[2] = '{addr: lsu_address_i,      data: lsu_data_i};
  assign src_entry[3] = '{addr: fdivsqrt_address_i, data: fdivsqrt_data_i};

  assign falu1_ready_o    = src_ready[0];
  assign falu2_ready_o    = src_ready[1];
  assign lsu_ready_o      = src_ready[2];
  assign fdivsqrt_ready_o = src_ready[3];

  // Readiness from registered free space only; lower priorities yield to valid higher ones
  always_comb begin
    free_c    = CNT_W'(DEPTH) - count_q;
    n_hi      = '0;
    src_ready = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_ready[k] = !rst && (free_c > n_hi);
      if (src_valid[k]) n_hi = n_hi + CNT_W'(1);
    end
  end

  assign src_fire = src_valid & src_ready;

  // Pack accepted results at tail in priority order; writes to P0 are dropped
  always_comb begin
    mem_d   = mem_q;
    tail_d  = tail_q;
    enq_cnt = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_fire[k] && (src_entry[k].addr != '0)) begin
        mem_d[tail_d] = src_entry[k];
        tail_d        = tail_d + PTR_W'(1);
        enq_cnt       = enq_cnt + CNT_W'(1);
      end
    end
  end

  // Entries shown on the lanes this cycle are always consumed
  always_comb begin
    deq_cnt = (count_q >= CNT_W'(2)) ? CNT_W'(2) : count_q;
    count_d = count_q + enq_cnt - deq_cnt;
    head_d  = head_q + PTR_W'(deq_cnt);
  end

  // Next lane contents come from the post-update FIFO so new entries show one cycle later
  always_comb begin
    lane0_valid_d = (count_d >= CNT_W'(1));
    lane1_valid_d = (count_d >= CNT_W'(2));
    lane0_d       = '0;
    lane1_d       = '0;
    if (lane0_valid_d) lane0_d = mem_d[head_d];
    if (lane1_valid_d) lane1_d = mem_d[head_d + PTR_W'(1)];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      lane0_valid_q <= 1'b0;
      lane1_valid_q <= 1'b0;
      lane0_q       <= '0;
      lane1_q       <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      empty_q       <= (count_d == '0);
      lane0_valid_q <= lane0_valid_d;
      lane1_valid_q <= lane1_valid_d;
      lane0_q       <= lane0_d;
      lane1_q       <= lane1_d;
    end
  end

  assign wr_first_valid_o    = lane0_valid_q;
  assign wr_first_address_o  = lane0_q.addr;
  assign wr_first_data_o     = lane0_q.data;
  assign wr_second_valid_o   = lane1_valid_q;
  assign wr_second_address_o = lane1_q.addr;
  assign wr_second_data_o    = lane1_q.data;
  assign count_o             = count_q;
  assign empty_o             = empty_q;

endmodule

// File: tb/tb_fp_wrb_buffer.sv
// Bench for fp_wrb_buffer: directed table, hand sequences and random traffic,
// all checked against a queue-based model of the buffer contents.
module tb_fp_wrb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v;
  logic [5:0]  a [4];
  logic [63:0] d [4];
  logic [3:0]  r;

  logic        wr_first_valid_o, wr_second_valid_o;
  logic [5:0]  wr_first_address_o, wr_second_address_o;
  logic [63:0] wr_first_data_o, wr_second_data_o;
  logic [3:0]  count_o;
  logic        empty_o;

  always #5 clk = ~clk;

  fp_wrb_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .falu1_valid_i       (v[0]),
    .falu1_address_i     (a[0]),
    .falu1_data_i        (d[0]),
    .falu1_ready_o       (r[0]),
    .falu2_valid_i       (v[1]),
    .falu2_address_i     (a[1]),
    .falu2_data_i        (d[1]),
    .falu2_ready_o       (r[1]),
    .lsu_valid_i         (v[2]),
    .lsu_address_i       (a[2]),
    .lsu_data_i          (d[2]),
    .lsu_ready_o         (r[2]),
    .fdivsqrt_valid_i    (v[3]),
    .fdivsqrt_address_i  (a[3]),
    .fdivsqrt_data_i     (d[3]),
    .fdivsqrt_ready_o    (r[3]),
    .wr_first_valid_o    (wr_first_valid_o),
    .wr_first_address_o  (wr_first_address_o),
    .wr_first_data_o     (wr_first_data_o),
    .wr_second_valid_o   (wr_second_valid_o),
    .wr_second_address_o (wr_second_address_o),
    .wr_second_data_o    (wr_second_data_o),
    .count_o             (count_o),
    .empty_o             (empty_o)
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [63:0] d;
  } ent_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         exp_count;
  } vec_t;

  ent_t        q [$];
  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  acc      = 4'h0;
  logic [63:0] seq      = 64'd1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Readiness straight from the rules: free slots must exceed valid higher-priority requests
  function automatic logic [3:0] model_ready();
    logic [3:0] rdy;
    int free, n;
    free = 8 - q.size();
    n    = 0;
    rdy  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      rdy[k] = !rst && (free > n);
      if (v[k]) n++;
    end
    return rdy;
  endfunction

  // Compare one cycle against the model, then advance the model across the clock edge
  task automatic cyc();
    logic [3:0] mr;
    int npop;
    #1;
    mr = model_ready();
    chk("ready", 64'(r), 64'(mr));
    chk("count", 64'(count_o), 64'(q.size()));
    chk("empty", 64'(empty_o), 64'(q.size() == 0));
    chk("l0_valid", 64'(wr_first_valid_o), 64'(q.size() >= 1));
    chk("l0_addr", 64'(wr_first_address_o), (q.size() >= 1) ? 64'(q[0].a) : 64'd0);
    chk("l0_data", wr_first_data_o, (q.size() >= 1) ? q[0].d : 64'd0);
    chk("l1_valid", 64'(wr_second_valid_o), 64'(q.size() >= 2));
    chk("l1_addr", 64'(wr_second_address_o), (q.size() >= 2) ? 64'(q[1].a) : 64'd0);
    chk("l1_data", wr_second_data_o, (q.size() >= 2) ? q[1].d : 64'd0);
    acc = v & mr;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      npop = (q.size() >= 2) ? 2 : q.size();
      repeat (npop) void'(q.pop_front());
      for (int k = 0; k < 4; k++)
        if (acc[k] && a[k] != 6'd0) q.push_back('{a: a[k], d: d[k]});
    end
    #1;
  endtask

  // Fresh payloads except where a source is still waiting on its handshake
  task automatic drive(input logic [3:0] vv, input bit rnd);
    for (int k = 0; k < 4; k++) begin
      if (!(v[k] && !acc[k])) begin
        if (rnd) begin
          a[k] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          d[k] = {$urandom, $urandom};
        end else begin
          a[k] = 6'(64'd1 + seq % 64'd63);
          d[k] = seq;
          seq  = seq + 64'd1;
        end
      end
    end
    v = vv | (v & ~acc);
    if (!rnd) v = vv;
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'hf,    4'hf,    0};
    tbl[1]  = '{4'hf,    4'hf,    4};
    tbl[2]  = '{4'hf,    4'h3,    6};
    tbl[3]  = '{4'hf,    4'h3,    6};
    tbl[4]  = '{4'h0,    4'hf,    6};
    tbl[5]  = '{4'h0,    4'hf,    4};
    tbl[6]  = '{4'h0,    4'hf,    2};
    tbl[7]  = '{4'h0,    4'hf,    0};
    tbl[8]  = '{4'hf,    4'hf,    0};
    tbl[9]  = '{4'hf,    4'hf,    4};
    tbl[10] = '{4'b1011, 4'b0011, 6};
    tbl[11] = '{4'b1000, 4'hf,    6};

    v = 4'h0;
    for (int k = 0; k < 4; k++) begin a[k] = 6'd0; d[k] = 64'd0; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(r), 64'd0);
    rst = 1'b0;
    cyc();

    // Directed table: full-pressure fill, drain, and tight-space priority
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, 1'b0);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(r), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].exp_count));
      cyc();
    end

    // Reset with five entries held
    v = 4'h0;
    chk("pre_rst_count", 64'(count_o), 64'd5);
    rst = 1'b1;
    #1;
    chk("rst_hi_ready", 64'(r), 64'd0);
    cyc();
    chk("post_rst_count", 64'(count_o), 64'd0);
    chk("post_rst_l0v", 64'(wr_first_valid_o), 64'd0);
    chk("post_rst_l1v", 64'(wr_second_valid_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(r), 64'hf);
    cyc();

    // Four results in one cycle, drained two at a time
    v = 4'hf;
    a[0] = 6'd3; a[1] = 6'd4; a[2] = 6'd5; a[3] = 6'd6;
    d[0] = 64'hA; d[1] = 64'hB; d[2] = 64'hC; d[3] = 64'hD;
    #1;
    chk("t1_ready", 64'(r), 64'hf);
    cyc();
    v = 4'h0;
    chk("t1_l0", {wr_first_address_o, wr_first_data_o[57:0]}, {6'd3, 58'hA});
    chk("t1_l1", {wr_second_address_o, wr_second_data_o[57:0]}, {6'd4, 58'hB});
    cyc();
    chk("t1_l0b", {wr_first_address_o, wr_first_data_o[57:0]}, {6'd5, 58'hC});
    chk("t1_l1b", {wr_second_address_o, wr_second_data_o[57:0]}, {6'd6, 58'hD});
    cyc();
    chk("t1_empty", 64'(empty_o), 64'd1);
    cyc();

    // P0 write is handshaken but not stored
    v = 4'b0011;
    a[0] = 6'd0; d[0] = 64'h55;
    a[1] = 6'd9; d[1] = 64'h99;
    #1;
    chk("t4_ready", 64'(r[1:0]), 64'h3);
    cyc();
    v = 4'h0;
    chk("t4_l0", {wr_first_address_o, wr_first_data_o[57:0]}, {6'd9, 58'h99});
    chk("t4_l1v", 64'(wr_second_valid_o), 64'd0);
    chk("t4_count", 64'(count_o), 64'd1);
    cyc();
    cyc();

    // Ascending data across pointer wrap: 1/cycle then 2/cycle
    for (int i = 0; i < 5; i++) begin drive(4'b0001, 1'b0); cyc(); end
    for (int i = 0; i < 3; i++) begin drive(4'b0011, 1'b0); cyc(); end
    v = 4'h0;
    for (int i = 0; i < 6; i++) cyc();

    // Random traffic at several offered loads
    acc = 4'h0;
    foreach (tbl[p]) begin
      int pct;
      pct = (p % 4 == 0) ? 25 : (p % 4 == 1) ? 60 : (p % 4 == 2) ? 90 : 100;
      for (int i = 0; i < 60; i++) begin
        logic [3:0] vv;
        for (int k = 0; k < 4; k++) vv[k] = ($urandom_range(0, 99) < pct);
        drive(vv, 1'b1);
        cyc();
      end
    end
    v = 4'h0;
    for (int i = 0; i < 6; i++) cyc();
    chk("final_empty", 64'(empty_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
